// File: rtl/tinyalu_pkg.sv
// Shared types for the TinyALU command dispatcher.
// Opcodes match the existing TinyALU core encoding.
package tinyalu_pkg;

   typedef enum logic [2:0] {
      no_op  = 3'b000,
      add_op = 3'b001,
      and_op = 3'b010,
      xor_op = 3'b011,
      mul_op = 3'b100,
      rst_op = 3'b111
   } operation_t;

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      RECOVER
   } dispatcher_state_t;

   typedef struct packed {
      logic [7:0] a;
      logic [7:0] b;
      operation_t op;
   } cmd_t;

   localparam int RECOVER_CYCLES = 2;

endpackage

// File: rtl/tinyalu_dispatcher_if.sv
// Command, ALU and result buses of the dispatcher.
// slave = dispatcher side, master = environment side.
interface tinyalu_dispatcher_if
   import tinyalu_pkg::*;
#(
   parameter int TAG_W = 4
);

   logic             cmd_valid;
   logic             cmd_ready;
   logic [7:0]       cmd_a;
   logic [7:0]       cmd_b;
   operation_t       cmd_op;

   logic [7:0]       alu_a;
   logic [7:0]       alu_b;
   operation_t       alu_op;
   logic             alu_start;
   logic             alu_reset_n;
   logic             alu_done;
   logic [15:0]      alu_result;

   logic             res_valid;
   logic             res_ready;
   logic [15:0]      res_data;
   logic [TAG_W-1:0] res_tag;
   logic             res_err;

   modport slave (
      input  cmd_valid, cmd_a, cmd_b, cmd_op,
      output cmd_ready,
      output alu_a, alu_b, alu_op, alu_start, alu_reset_n,
      input  alu_done, alu_result,
      output res_valid, res_data, res_tag, res_err,
      input  res_ready
   );

   modport master (
      output cmd_valid, cmd_a, cmd_b, cmd_op,
      input  cmd_ready,
      input  alu_a, alu_b, alu_op, alu_start, alu_reset_n,
      output alu_done, alu_result,
      input  res_valid, res_data, res_tag, res_err,
      output res_ready
   );

endinterface

// File: rtl/tinyalu_cmd_fifo.sv
// Command FIFO with registered full/empty flags.
// Pointers carry an extra MSB to tell full from empty.
module tinyalu_cmd_fifo #(
   parameter int DEPTH = 4,
   parameter int W     = 23
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         push,
   input  logic         pop,
   input  logic [W-1:0] wdata,
   output logic [W-1:0] rdata,
   output logic         full,
   output logic         empty
);

   localparam int AW = $clog2(DEPTH);

   logic [W-1:0] mem [DEPTH];
   logic [AW:0]  wptr;
   logic [AW:0]  rptr;
   logic [AW:0]  wptr_n;
   logic [AW:0]  rptr_n;
   logic         do_push;
   logic         do_pop;

   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign wptr_n  = wptr + {{AW{1'b0}}, do_push};
   assign rptr_n  = rptr + {{AW{1'b0}}, do_pop};
   assign rdata   = mem[rptr[AW-1:0]];

   always_ff @(posedge clk) begin
      if (reset) begin
         wptr  <= '0;
         rptr  <= '0;
         full  <= 1'b0;
         empty <= 1'b1;
      end else begin
         wptr  <= wptr_n;
         rptr  <= rptr_n;
         empty <= (wptr_n == rptr_n);
         full  <= (wptr_n[AW] != rptr_n[AW]) &&
                  (wptr_n[AW-1:0] == rptr_n[AW-1:0]);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wptr[AW-1:0]] <= wdata;
      end
   end

endmodule

// File: rtl/tinyalu_dispatcher.sv
// Buffers tagged commands and drives the TinyALU start/done
// protocol one operation at a time, with hang recovery.
module tinyalu_dispatcher
   import tinyalu_pkg::*;
#(
   parameter int DEPTH   = 4,
   parameter int TAG_W   = 4,
   parameter int TIMEOUT = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   tinyalu_dispatcher_if.slave  bus
);

   localparam int EW = $bits(cmd_t) + TAG_W;
   localparam int CW = $clog2(TIMEOUT + 1);
   localparam int RW = $clog2(RECOVER_CYCLES + 1);

   dispatcher_state_t state;
   dispatcher_state_t state_n;

   logic [TAG_W-1:0] tag_cnt;
   logic [TAG_W-1:0] cur_tag;
   logic [TAG_W-1:0] head_tag;
   cmd_t             in_cmd;
   cmd_t             head_cmd;
   logic [EW-1:0]    fifo_out;
   logic             push;
   logic             pop;
   logic             full;
   logic             empty;
   logic             slot_free;
   logic             launch;
   logic             finish;
   logic             expire;
   logic [CW-1:0]    tmo_cnt;
   logic [RW-1:0]    rec_cnt;

   assign in_cmd        = '{a: bus.cmd_a, b: bus.cmd_b, op: bus.cmd_op};
   assign push          = bus.cmd_valid && !full;
   assign bus.cmd_ready = !full;
   assign slot_free     = !bus.res_valid || bus.res_ready;
   assign {head_cmd, head_tag} = fifo_out;

   tinyalu_cmd_fifo #(
      .DEPTH (DEPTH),
      .W     (EW)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push),
      .pop   (pop),
      .wdata ({in_cmd, tag_cnt}),
      .rdata (fifo_out),
      .full  (full),
      .empty (empty)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_n;
      end
   end

   always_comb begin
      state_n = state;
      pop     = 1'b0;
      launch  = 1'b0;
      finish  = 1'b0;
      expire  = 1'b0;
      unique case (state)
         IDLE: begin
            if (!empty && slot_free) begin
               pop = 1'b1;
               unique case (1'b1)
                  head_cmd.op == no_op: ;
                  head_cmd.op == rst_op: state_n = RECOVER;
                  default: begin
                     launch  = 1'b1;
                     state_n = BUSY;
                  end
               endcase
            end
         end
         BUSY: begin
            if (bus.alu_done) begin
               finish  = 1'b1;
               state_n = IDLE;
            end else if (tmo_cnt == CW'(TIMEOUT)) begin
               expire  = 1'b1;
               state_n = RECOVER;
            end
         end
         RECOVER: begin
            if (rec_cnt == RW'(RECOVER_CYCLES - 1)) begin
               state_n = IDLE;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   // ALU reset is held low for the whole RECOVER dwell.
   assign bus.alu_reset_n = !reset && (state != RECOVER);

   always_ff @(posedge clk) begin
      if (reset) begin
         tag_cnt       <= '0;
         cur_tag       <= '0;
         tmo_cnt       <= '0;
         rec_cnt       <= '0;
         bus.alu_a     <= '0;
         bus.alu_b     <= '0;
         bus.alu_op    <= no_op;
         bus.alu_start <= 1'b0;
         bus.res_valid <= 1'b0;
         bus.res_data  <= '0;
         bus.res_tag   <= '0;
         bus.res_err   <= 1'b0;
      end else begin
         if (push) begin
            tag_cnt <= tag_cnt + TAG_W'(1);
         end
         tmo_cnt <= (state == BUSY) ? tmo_cnt + CW'(1) : '0;
         rec_cnt <= (state == RECOVER) ? rec_cnt + RW'(1) : '0;
         if (launch) begin
            bus.alu_a     <= head_cmd.a;
            bus.alu_b     <= head_cmd.b;
            bus.alu_op    <= head_cmd.op;
            cur_tag       <= head_tag;
            bus.alu_start <= 1'b1;
         end else if (finish || expire) begin
            bus.alu_start <= 1'b0;
         end
         // Slot is known empty while BUSY, so a load never overwrites.
         if (finish || expire) begin
            bus.res_valid <= 1'b1;
            bus.res_data  <= finish ? bus.alu_result : 16'h0000;
            bus.res_err   <= expire;
            bus.res_tag   <= cur_tag;
         end else if (bus.res_ready) begin
            bus.res_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_tinyalu_dispatcher.sv
// Scoreboard bench for tinyalu_dispatcher with a TinyALU model.
// Directed vectors; monitor compares results as they leave.
module tb_tinyalu_dispatcher;
   import tinyalu_pkg::*;

   localparam int DEPTH   = 4;
   localparam int TAG_W   = 4;
   localparam int TIMEOUT = 16;

   typedef struct {
      logic [15:0]      data;
      logic [TAG_W-1:0] tag;
      logic             err;
   } exp_t;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   tinyalu_dispatcher_if #(.TAG_W(TAG_W)) bus();

   tinyalu_dispatcher #(
      .DEPTH   (DEPTH),
      .TAG_W   (TAG_W),
      .TIMEOUT (TIMEOUT)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   exp_t             sb[$];
   int               n_cmp = 0;
   int               n_err = 0;
   int               cyc = 0;
   int               n_res = 0;
   int               n_start = 0;
   int               n_low = 0;
   int               low_run = 0;
   int               last_low = 0;
   int               hang_req = 0;
   logic [TAG_W-1:0] tb_tag = '0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Result monitor and protocol observers
   initial begin
      logic prev_start;
      prev_start = 1'b0;
      forever begin
         @(negedge clk);
         if (reset) begin
            prev_start = 1'b0;
            low_run = 0;
            continue;
         end
         if (bus.alu_start && !prev_start) n_start++;
         prev_start = bus.alu_start;
         if (!bus.alu_reset_n) begin
            low_run++;
         end else if (low_run > 0) begin
            last_low = low_run;
            n_low++;
            low_run = 0;
         end
         if (bus.res_valid && bus.res_ready) begin
            n_res++;
            if (sb.size() == 0) begin
               n_cmp++;
               n_err++;
               $display("FAIL unexpected result: tag %0d data 0x%0h",
                        bus.res_tag, bus.res_data);
            end else begin
               exp_t e;
               e = sb.pop_front();
               check("res_data", bus.res_data, e.data);
               check("res_tag", bus.res_tag, e.tag);
               check("res_err", bus.res_err, e.err);
            end
         end
      end
   end

   // TinyALU model: 1-cycle add/and/xor, 3-cycle mul, optional hang
   initial begin
      int          cnt;
      int          hang_used;
      bit          armed;
      bit          hung;
      logic [15:0] r;
      cnt = 0; hang_used = 0; armed = 0; hung = 0; r = '0;
      bus.alu_done = 1'b0;
      bus.alu_result = '0;
      forever begin
         @(posedge clk);
         #1;
         bus.alu_done = 1'b0;
         if (!bus.alu_reset_n) begin
            armed = 0;
            hung = 0;
         end else if (armed) begin
            if (!hung) begin
               cnt--;
               if (cnt == 0) begin
                  bus.alu_done = 1'b1;
                  bus.alu_result = r;
                  armed = 0;
               end
            end
         end else if (bus.alu_start) begin
            armed = 1;
            hung = (hang_req > hang_used);
            if (hung) hang_used++;
            cnt = (bus.alu_op == mul_op) ? 3 : 1;
            case (bus.alu_op)
               add_op:  r = 16'(bus.alu_a) + 16'(bus.alu_b);
               and_op:  r = {8'h00, bus.alu_a & bus.alu_b};
               xor_op:  r = {8'h00, bus.alu_a ^ bus.alu_b};
               mul_op:  r = 16'(bus.alu_a) * 16'(bus.alu_b);
               default: r = 16'h0000;
            endcase
         end
      end
   end

   task automatic check_rst();
      check("rst cmd_ready", bus.cmd_ready, 1);
      check("rst alu_start", bus.alu_start, 0);
      check("rst alu_a", bus.alu_a, 0);
      check("rst alu_b", bus.alu_b, 0);
      check("rst alu_op", bus.alu_op, 0);
      check("rst alu_reset_n", bus.alu_reset_n, 0);
      check("rst res_valid", bus.res_valid, 0);
      check("rst res_data", bus.res_data, 0);
      check("rst res_tag", bus.res_tag, 0);
      check("rst res_err", bus.res_err, 0);
   endtask

   task automatic do_reset(input bit chk);
      reset = 1'b1;
      bus.cmd_valid = 1'b0;
      @(posedge clk);
      @(negedge clk);
      if (chk) check_rst();
      @(posedge clk);
      #1;
      sb.delete();
      tb_tag = '0;
      reset = 1'b0;
      @(negedge clk);
      if (chk) check("alu_reset_n after reset", bus.alu_reset_n, 1);
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [7:0] a, input logic [7:0] b,
                       input operation_t op, input logic [15:0] exp_data,
                       input logic exp_err, input int bound,
                       output bit acc, output int acc_cyc);
      bus.cmd_valid = 1'b1;
      bus.cmd_a = a;
      bus.cmd_b = b;
      bus.cmd_op = op;
      acc = 0;
      acc_cyc = -1;
      for (int i = 0; i < bound && !acc; i++) begin
         @(negedge clk);
         acc = bus.cmd_ready;
         acc_cyc = cyc;
         @(posedge clk);
         #1;
      end
      if (acc) begin
         if (op != no_op && op != rst_op)
            sb.push_back('{exp_data, tb_tag, exp_err});
         tb_tag++;
      end
      bus.cmd_valid = 1'b0;
   endtask

   task automatic send_ok(input logic [7:0] a, input logic [7:0] b,
                          input operation_t op, input logic [15:0] exp_data,
                          output int acc_cyc);
      bit acc;
      send(a, b, op, exp_data, 1'b0, 60, acc, acc_cyc);
      check("cmd accepted", acc, 1);
   endtask

   task automatic wait_high(input bit on_res, output int c);
      c = -1;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (on_res ? bus.res_valid : bus.alu_start) begin
            c = cyc;
            break;
         end
      end
   endtask

   task automatic drain(input string name);
      int i;
      i = 0;
      while ((sb.size() != 0 || bus.res_valid) && i < 500) begin
         @(negedge clk);
         i++;
      end
      check({name, " drained"}, sb.size(), 0);
      repeat (3) @(posedge clk);
      #1;
   endtask

   initial begin
      bit acc;
      int n0, c, c2, k, r0, s0, l0;
      bus.cmd_valid = 1'b0;
      bus.cmd_a = '0;
      bus.cmd_b = '0;
      bus.cmd_op = no_op;
      bus.res_ready = 1'b1;

      // reset values, then single add and mul with latency
      do_reset(1);
      send_ok(8'h12, 8'h34, add_op, 16'h0046, n0);
      wait_high(0, c);
      check("add start cycle", c, n0 + 2);
      wait_high(1, c);
      check("add result cycle", c, n0 + 4);
      drain("add");
      send_ok(8'hFF, 8'hFF, mul_op, 16'hFE01, n0);
      wait_high(1, c);
      check("mul result cycle", c, n0 + 6);
      drain("mul");

      // backpressure: 6 offered, 5 accepted
      do_reset(0);
      bus.res_ready = 1'b0;
      k = 0;
      for (int i = 0; i < 6; i++) begin
         send(8'(i + 1), 8'h10, add_op, 16'(i + 17), 1'b0,
              (i < 5) ? 4 : 8, acc, c);
         if (acc) k++;
      end
      check("backpressure accepted", k, 5);
      @(negedge clk);
      check("full cmd_ready", bus.cmd_ready, 0);
      check("held res_valid", bus.res_valid, 1);
      check("held res_data", bus.res_data, 16'h0011);
      check("held res_tag", bus.res_tag, 0);
      @(posedge clk);
      #1;
      bus.res_ready = 1'b1;
      drain("backpressure");

      // 20 commands: tag wrap
      do_reset(0);
      r0 = n_res;
      for (int i = 0; i < 20; i++)
         send_ok(8'(i), 8'hF0, add_op, 16'(i) + 16'h00F0, c);
      drain("tag wrap");
      check("tag wrap results", n_res - r0, 20);

      // hung ALU: timeout then recovery, then queued xor
      do_reset(0);
      hang_req++;
      l0 = n_low;
      send(8'h01, 8'h02, add_op, 16'h0000, 1'b1, 60, acc, n0);
      check("hang cmd accepted", acc, 1);
      send_ok(8'hF0, 8'h3C, xor_op, 16'h00CC, c);
      wait_high(0, c);
      check("hang start cycle", c, n0 + 2);
      wait_high(1, c2);
      check("timeout result cycle", c2, c + TIMEOUT + 1);
      drain("timeout");
      check("timeout recover pulses", n_low - l0, 1);
      check("timeout recover length", last_low, 2);

      // add, rst_op, no_op, and
      do_reset(0);
      r0 = n_res; s0 = n_start; l0 = n_low;
      send_ok(8'h05, 8'h07, add_op, 16'h000C, c);
      send_ok(8'h00, 8'h00, rst_op, 16'h0000, c);
      send_ok(8'h00, 8'h00, no_op, 16'h0000, c);
      send_ok(8'hF0, 8'h3C, and_op, 16'h0030, c);
      drain("rst/no_op");
      check("rst/no_op results", n_res - r0, 2);
      check("rst/no_op starts", n_start - s0, 2);
      check("rst_op recover pulses", n_low - l0, 1);
      check("rst_op recover length", last_low, 2);

      // reset mid-BUSY with 3 queued commands
      do_reset(0);
      hang_req++;
      for (int i = 0; i < 4; i++)
         send_ok(8'(i), 8'h01, add_op, 16'(i + 1), c);
      repeat (3) @(posedge clk);
      #1;
      r0 = n_res;
      do_reset(1);
      repeat (40) @(posedge clk);
      #1;
      check("aborted results", n_res - r0, 0);
      check("post-abort cmd_ready", bus.cmd_ready, 1);

      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

endmodule
